// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: default widths,
// the frame start marker and the loader state encoding.
package imem_loader_pkg;

  localparam int          ADDR_W_DEF    = 10;
  localparam int          INSTR_W_DEF   = 12;
  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int          OPC_W         = 4;
  localparam int          OPR_W         = 8;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LEN_HI = 4'd1,
    ST_LEN_LO = 4'd2,
    ST_W_HI   = 4'd3,
    ST_W_LO   = 4'd4,
    ST_WRITE  = 4'd5,
    ST_CHK    = 4'd6,
    ST_DONE   = 4'd7,
    ST_ERR    = 4'd8
  } state_t;

endpackage

// File: rtl/imem_loader.sv
// Framed byte-stream loader: packs byte pairs into instructions, writes them to
// imem from address 0 and releases the CPU only after a good checksum.
//
// state  | meaning
// IDLE   | hunting for SYNC_BYTE, other bytes dropped
// LEN_HI | expecting upper length bits
// LEN_LO | expecting lower length byte
// W_HI   | expecting opcode nibble byte
// W_LO   | expecting operand byte
// WRITE  | one-cycle imem write strobe, no byte accepted
// CHK    | expecting checksum byte
// DONE   | frame loaded, CPU released
// ERR    | frame rejected, CPU held
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W    = ADDR_W_DEF,
  parameter int         INSTR_W   = INSTR_W_DEF,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic               clk,
  input  logic               reset_loader,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  input  logic               load_req,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [ADDR_W:0]    word_count
);

  state_t              state, state_nx;
  logic                accept;
  logic [ADDR_W-9:0]   len_hi;
  logic [ADDR_W-1:0]   last_addr;
  logic [ADDR_W-1:0]   addr;
  logic [7:0]          sum;
  logic [OPC_W-1:0]    nib;
  logic [INSTR_W-1:0]  wdata;
  logic [ADDR_W:0]     wcount;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset_loader) begin
    if (reset_loader) state <= ST_IDLE;
    else              state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    imem_we  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (accept && in_data == SYNC_BYTE) state_nx = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        in_ready = 1'b1;
        if (accept) state_nx = (in_data[7:ADDR_W-8] != '0) ? ST_ERR : ST_LEN_LO;
      end
      ST_LEN_LO: begin
        in_ready = 1'b1;
        if (accept) state_nx = ST_W_HI;
      end
      ST_W_HI: begin
        in_ready = 1'b1;
        if (accept) state_nx = (in_data[7:OPC_W] != '0) ? ST_ERR : ST_W_LO;
      end
      ST_W_LO: begin
        in_ready = 1'b1;
        if (accept) state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        imem_we  = !load_req;
        state_nx = (addr == last_addr) ? ST_CHK : ST_W_HI;
      end
      ST_CHK: begin
        in_ready = 1'b1;
        if (accept) state_nx = (in_data == sum) ? ST_DONE : ST_ERR;
      end
      ST_DONE:  state_nx = ST_DONE;
      ST_ERR:   state_nx = ST_ERR;
      default:  state_nx = ST_ERR;
    endcase
    // load_req overrides everything, including a byte accepted this cycle
    if (load_req) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset_loader) begin
    if (reset_loader) begin
      len_hi    <= '0;
      last_addr <= '0;
      addr      <= '0;
      sum       <= '0;
      nib       <= '0;
      wdata     <= '0;
      wcount    <= '0;
    end else if (load_req) begin
      wcount <= '0;
    end else begin
      unique case (state)
        ST_LEN_HI: if (accept) len_hi <= in_data[ADDR_W-9:0];
        ST_LEN_LO: if (accept) begin
          last_addr <= {len_hi, in_data};
          addr      <= '0;
          sum       <= '0;
          wcount    <= '0;
        end
        ST_W_HI: if (accept) begin
          nib <= in_data[OPC_W-1:0];
          sum <= sum + in_data;
        end
        ST_W_LO: if (accept) begin
          wdata <= {nib, in_data};
          sum   <= sum + in_data;
        end
        // address holds on the last word so it never wraps past 3FF
        ST_WRITE: begin
          wcount <= wcount + (ADDR_W+1)'(1);
          if (addr != last_addr) addr <= addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = addr;
  assign imem_wdata = wdata;
  assign word_count = wcount;
  assign done       = (state == ST_DONE);
  assign error      = (state == ST_ERR);
  assign cpu_hold   = (state != ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame generator with a write scoreboard,
// literal frames that pin the expectations, and randomized frames with gaps.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_loader;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        load_req;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [11:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [10:0] word_count;

  int errors = 0;
  int checks = 0;
  logic [21:0] exp_q[$];
  logic [9:0]  last_we_addr;
  int          wr_cnt;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk(clk), .reset_loader(reset_loader), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .load_req(load_req), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error),
    .word_count(word_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every write strobe must match the next expected {addr,data}
  always @(negedge clk) begin
    if (!reset_loader) begin
      if (imem_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {10'd0, imem_addr, imem_wdata}, 32'hFFFF_FFFF);
        end else begin
          logic [21:0] e;
          e = exp_q.pop_front();
          chk("write_addr", imem_addr, e[21:12]);
          chk("write_data", imem_wdata, e[11:0]);
        end
        last_we_addr = imem_addr;
        wr_cnt++;
        chk("ready_during_write", in_ready, 1'b0);
      end
      chk("hold_vs_done", cpu_hold, !done);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready) begin
      @(negedge clk);
      t++;
      if (t > 50) begin
        chk("byte_accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_load_req();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    chk("lreq_hold", cpu_hold, 1'b1);
    chk("lreq_done", done, 1'b0);
    chk("lreq_err", error, 1'b0);
    chk("lreq_wc", word_count, 11'd0);
    chk("lreq_ready", in_ready, 1'b1);
  endtask

  task automatic check_status(input bit e_done, input bit e_err, input int e_wc);
    repeat (2) @(negedge clk);
    chk("st_done", done, e_done);
    chk("st_error", error, e_err);
    chk("st_hold", cpu_hold, !e_done);
    chk("st_wc", word_count, 32'(e_wc));
    chk("st_pending_writes", exp_q.size(), 0);
    chk("st_ready", in_ready, 1'b0);
  endtask

  // mode: 0 good, 1 bad checksum, 2 bad W_HI at word bad_k, 3 bad LEN_HI
  task automatic run_frame(input int n, input int mode, input int bad_k, input int junk, input bit gaps);
    logic [7:0]  s, b;
    logic [11:0] w;
    logic [9:0]  l;
    int          wc0;
    l   = 10'(n - 1);
    s   = 8'h00;
    wc0 = wr_cnt;
    for (int j = 0; j < junk; j++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h00;
      send_byte(b, gaps);
    end
    send_byte(8'hA5, gaps);
    if (mode == 3) begin
      send_byte({6'($urandom_range(1, 63)), l[9:8]}, gaps);
      check_status(1'b0, 1'b1, 0);
      return;
    end
    send_byte({6'd0, l[9:8]}, gaps);
    send_byte(l[7:0], gaps);
    for (int k = 0; k < n; k++) begin
      w = 12'($urandom);
      if (mode == 2 && k == bad_k) begin
        send_byte({4'($urandom_range(1, 15)), w[11:8]}, gaps);
        check_status(1'b0, 1'b1, k);
        chk("no_write_after_err", wr_cnt - wc0, k);
        return;
      end
      exp_q.push_back({10'(k), w});
      send_byte({4'h0, w[11:8]}, gaps);
      send_byte(w[7:0], gaps);
      s = s + {4'h0, w[11:8]} + w[7:0];
    end
    send_byte((mode == 1) ? s + 8'h01 : s, gaps);
    check_status(mode == 0, mode == 1, n);
  endtask

  initial begin
    logic [7:0] f1 [8];
    logic [7:0] f3 [8];
    f1 = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h23, 8'h0F, 8'hFF, 8'h32};
    f3 = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h05, 8'h5A, 8'h5F};
    reset_loader = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    load_req = 1'b0;
    wr_cnt   = 0;
    last_we_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_we", imem_we, 1'b0);
    chk("rst_addr", imem_addr, 10'd0);
    chk("rst_wdata", imem_wdata, 12'd0);
    chk("rst_hold", cpu_hold, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_err", error, 1'b0);
    chk("rst_wc", word_count, 11'd0);
    reset_loader = 1'b0;
    @(negedge clk);

    // Literal frame: two words, good checksum
    exp_q.push_back({10'h000, 12'h123});
    exp_q.push_back({10'h001, 12'hFFF});
    for (int i = 0; i < 8; i++) send_byte(f1[i], 1'b0);
    check_status(1'b1, 1'b0, 2);

    // Same frame with a bad checksum
    do_load_req();
    f1[7] = 8'h33;
    exp_q.push_back({10'h000, 12'h123});
    exp_q.push_back({10'h001, 12'hFFF});
    for (int i = 0; i < 8; i++) send_byte(f1[i], 1'b0);
    check_status(1'b0, 1'b1, 2);

    // Leading junk dropped
    do_load_req();
    exp_q.push_back({10'h000, 12'h55A});
    for (int i = 0; i < 8; i++) send_byte(f3[i], 1'b1);
    check_status(1'b1, 1'b0, 1);

    // Bad W_HI, then bad LEN_HI
    do_load_req();
    exp_q.push_back({10'h000, 12'h123});
    send_byte(8'hA5, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h01, 1'b0); send_byte(8'h23, 1'b0); send_byte(8'h15, 1'b0);
    check_status(1'b0, 1'b1, 1);
    do_load_req();
    send_byte(8'hA5, 1'b0); send_byte(8'h04, 1'b0);
    check_status(1'b0, 1'b1, 0);

    // load_req after DONE, then a fresh 1-word frame
    do_load_req();
    run_frame(1, 0, 0, 0, 1'b0);
    do_load_req();
    run_frame(1, 0, 0, 2, 1'b1);

    // Maximum length with gaps
    do_load_req();
    wr_cnt = 0;
    run_frame(1024, 0, 0, 0, 1'b1);
    chk("max_write_count", wr_cnt, 1024);
    chk("max_last_addr", last_we_addr, 10'h3FF);

    // Randomized frames
    for (int r = 0; r < 12; r++) begin
      int n, m;
      n = $urandom_range(1, 40);
      m = $urandom_range(0, 3);
      do_load_req();
      run_frame(n, m, $urandom_range(0, n - 1), $urandom_range(0, 3), 1'($urandom));
    end

    // Reset mid-frame
    do_load_req();
    exp_q.push_back({10'h000, 12'h123});
    send_byte(8'hA5, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h03, 1'b0);
    send_byte(8'h01, 1'b0); send_byte(8'h23, 1'b0);
    @(negedge clk);
    send_byte(8'h04, 1'b0);
    reset_loader = 1'b1;
    #1;
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_we", imem_we, 1'b0);
    chk("mid_rst_addr", imem_addr, 10'd0);
    chk("mid_rst_wdata", imem_wdata, 12'd0);
    chk("mid_rst_hold", cpu_hold, 1'b1);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_err", error, 1'b0);
    chk("mid_rst_wc", word_count, 11'd0);
    chk("mid_rst_pending", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    reset_loader = 1'b0;
    @(negedge clk);
    run_frame(3, 0, 0, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
